// File: rtl/fila_if.sv
// Byte-queue bus for fila: upstream handshake, pop request and queue status.
// The master side drives bytes and pop requests; the slave side is the queue.
interface fila_if #(
  parameter int DEPTH = 8
) ();
  logic [7:0]              data_in;
  logic                    enqueue_in;
  logic                    ack_out;
  logic                    dequeue_in;
  logic [7:0]              data_out;
  logic [$clog2(DEPTH):0]  len_out;
  logic                    full_out;
  logic                    empty_out;

  modport master (
    output data_in, enqueue_in, dequeue_in,
    input  ack_out, data_out, len_out, full_out, empty_out
  );

  modport slave (
    input  data_in, enqueue_in, dequeue_in,
    output ack_out, data_out, len_out, full_out, empty_out
  );
endinterface

// File: rtl/fila.sv
// fila: circular byte queue with a level/ack upstream handshake and registered pop output.
// Optional FILA_ERR_EN adds a sticky err_out for empty pops and writes refused while full.
module fila #(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  fila_if.slave bus
`ifdef FILA_ERR_EN
  ,
  output logic  err_out
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } state_t;

  state_t          state_q, state_d;
  logic            ack_q, ack_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   len_q, len_d;
  logic [7:0]      data_out_q, data_out_d;
  logic [7:0]      mem [DEPTH];

  logic            full;
  logic            empty;
  logic            do_write;
  logic            do_pop;

  assign full  = (len_q == LW'(DEPTH));
  assign empty = (len_q == '0);

  // A byte is taken only from IDLE, so a level held through WAIT_LOW is never stored twice.
  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    do_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enqueue_in && !full) begin
          do_write = 1'b1;
          ack_d    = 1'b1;
          state_d  = ACK;
        end
      end
      ACK: begin
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!bus.enqueue_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    do_pop     = bus.dequeue_in && !empty;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_out_d = data_out_q;
    len_d      = len_q;
    if (do_write) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d   = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      data_out_d = mem[rd_ptr_q];
    end
    case ({do_write, do_pop})
      2'b10:   len_d = len_q + 1'b1;
      2'b01:   len_d = len_q - 1'b1;
      default: len_d = len_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      data_out_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      len_q      <= len_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage has no reset; an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_q] <= bus.data_in;
    end
  end

  assign bus.ack_out   = ack_q;
  assign bus.data_out  = data_out_q;
  assign bus.len_out   = len_q;
  assign bus.full_out  = full;
  assign bus.empty_out = empty;

`ifdef FILA_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q
          | (bus.dequeue_in && empty)
          | (bus.enqueue_in && full && (state_q == IDLE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_out = err_q;
`endif

endmodule

// File: tb/tb_fila.sv
// Directed table-driven bench for fila (DEPTH=8): single byte, fill/overflow, wrap,
// pop-while-full, simultaneous push/pop, empty pop and reset during a handshake.
module tb_fila;

  localparam int DEPTH = 8;

  typedef struct {
    logic       enq;
    logic       deq;
    logic [7:0] din;
    logic       exp_ack;
    logic [7:0] exp_dout;
    logic [3:0] exp_len;
  } vec_t;

  logic clk;
  logic reset;
  int   vec_count;
  int   miss_count;
  vec_t vecs[$];
  logic [7:0] exp_dout;

  fila_if #(.DEPTH(DEPTH)) bus ();

`ifdef FILA_ERR_EN
  logic err_out;
  fila #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus), .err_out(err_out));
`else
  fila #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add_vec(input logic enq, input logic deq, input logic [7:0] din,
                                  input logic ack, input logic [3:0] len);
    vec_t v;
    v.enq      = enq;
    v.deq      = deq;
    v.din      = din;
    v.exp_ack  = ack;
    v.exp_dout = exp_dout;
    v.exp_len  = len;
    vecs.push_back(v);
  endfunction

  // One full upstream handshake: offer byte, drop the level, return to IDLE.
  function automatic void push_rows(input logic [7:0] d, input logic [3:0] len_after);
    add_vec(1'b1, 1'b0, d,     1'b1, len_after);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, len_after);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, len_after);
  endfunction

  function automatic void pop_row(input logic [7:0] d, input logic [3:0] len_after);
    exp_dout = d;
    add_vec(1'b0, 1'b1, 8'h00, 1'b0, len_after);
  endfunction

  task automatic applyStimulus(input logic enq, input logic deq, input logic [7:0] din);
    bus.enqueue_in = enq;
    bus.dequeue_in = deq;
    bus.data_in    = din;
  endtask

  task automatic checkOutput(input string name, input logic ack, input logic [7:0] dout,
                             input logic [3:0] len);
    logic exp_full;
    logic exp_empty;
    exp_full  = (len == 4'd8);
    exp_empty = (len == 4'd0);
    vec_count++;
    if (bus.ack_out !== ack || bus.data_out !== dout || bus.len_out !== len ||
        bus.full_out !== exp_full || bus.empty_out !== exp_empty) begin
      miss_count++;
      $display("[TB] FAIL %s: got ack=%b dout=%h len=%0d full=%b empty=%b, want ack=%b dout=%h len=%0d full=%b empty=%b",
               name, bus.ack_out, bus.data_out, bus.len_out, bus.full_out, bus.empty_out,
               ack, dout, len, exp_full, exp_empty);
    end
  endtask

  initial begin
    vec_count  = 0;
    miss_count = 0;
    exp_dout   = 8'h00;

    // Single byte held for three cycles, then popped, then an empty pop.
    add_vec(1'b1, 1'b0, 8'hA5, 1'b1, 4'd1);
    add_vec(1'b1, 1'b0, 8'hA5, 1'b0, 4'd1);
    add_vec(1'b1, 1'b0, 8'hA5, 1'b0, 4'd1);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd1);
    pop_row(8'hA5, 4'd0);
    add_vec(1'b0, 1'b1, 8'h00, 1'b0, 4'd0);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd0);
    // Fill to full, then a ninth byte held and refused.
    for (int i = 1; i <= 8; i++) push_rows(8'(i), 4'(i));
    for (int i = 0; i < 3; i++) add_vec(1'b1, 1'b0, 8'hFF, 1'b0, 4'd8);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd8);
    // Wrap: pop three, push three more.
    pop_row(8'h01, 4'd7);
    pop_row(8'h02, 4'd6);
    pop_row(8'h03, 4'd5);
    push_rows(8'h09, 4'd6);
    push_rows(8'h0A, 4'd7);
    push_rows(8'h0B, 4'd8);
    // Pop while full: write refused this cycle, taken on the next.
    exp_dout = 8'h04;
    add_vec(1'b1, 1'b1, 8'h0C, 1'b0, 4'd7);
    add_vec(1'b1, 1'b0, 8'h0C, 1'b1, 4'd8);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd8);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd8);
    for (int i = 0; i < 8; i++) pop_row(8'(8'h05 + i), 4'(7 - i));
    // Simultaneous push and pop at len 4.
    for (int i = 0; i < 4; i++) push_rows(8'(8'h10 + i), 4'(i + 1));
    exp_dout = 8'h10;
    add_vec(1'b1, 1'b1, 8'h14, 1'b1, 4'd4);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd4);
    add_vec(1'b0, 1'b0, 8'h00, 1'b0, 4'd4);
    for (int i = 0; i < 4; i++) pop_row(8'(8'h11 + i), 4'(3 - i));

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 1'b0, 8'h00, 4'd0);
`ifdef FILA_ERR_EN
    vec_count++;
    if (err_out !== 1'b0) begin
      miss_count++;
      $display("[TB] FAIL err_reset: got err_out=%b, want 0", err_out);
    end
`endif
    reset = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].enq, vecs[i].deq, vecs[i].din);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_ack, vecs[i].exp_dout, vecs[i].exp_len);
    end

`ifdef FILA_ERR_EN
    vec_count++;
    if (err_out !== 1'b1) begin
      miss_count++;
      $display("[TB] FAIL err_sticky: got err_out=%b, want 1", err_out);
    end
`endif

    // Reset asserted while in ACK: outputs clear at once, FSM back in IDLE after release.
    applyStimulus(1'b1, 1'b0, 8'h55);
    @(posedge clk);
    #1;
    checkOutput("mid_hs_ack", 1'b1, 8'h14, 4'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("mid_hs_async", 1'b0, 8'h00, 4'd0);
`ifdef FILA_ERR_EN
    vec_count++;
    if (err_out !== 1'b0) begin
      miss_count++;
      $display("[TB] FAIL err_cleared: got err_out=%b, want 0", err_out);
    end
`endif
    applyStimulus(1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("mid_hs_held", 1'b0, 8'h00, 4'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 8'h66);
    @(posedge clk);
    #1;
    checkOutput("post_reset_push", 1'b1, 8'h00, 4'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("post_reset_pop", 1'b0, 8'h66, 4'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
